// File: rtl/hamming_enc_sched.sv
// Round-robin front end that shares one serial Hamming(7,4) encoder between two
// nibble requesters and returns each codeword tagged with its source.
module hamming_enc_sched #(
    parameter int ENC_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [3:0] data1,
    output logic       ack1,
    output logic       enc_data,
    output logic       enc_write,
    input  logic [6:0] enc_code,
    output logic [6:0] code_out,
    output logic       code_src,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       busy
);

    // Handshake: code_out/code_src are held while code_valid=1 and the word
    // is consumed on a rising edge where code_valid=1 and code_ready=1.
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_OUT} state_t;

    localparam logic [2:0] LAT_LAST = 3'((ENC_LAT == 0) ? 0 : ENC_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [2:0] r_wcnt;
    logic [2:0] w_wcnt_nxt;
    logic [3:0] r_buf;
    logic [3:0] w_buf_nxt;
    logic       r_src;
    logic       w_src_nxt;
    logic       r_last_grant;
    logic       w_last_nxt;
    logic       r_ack0;
    logic       w_ack0_nxt;
    logic       r_ack1;
    logic       w_ack1_nxt;
    logic       r_enc_data;
    logic       w_enc_data_nxt;
    logic       r_enc_write;
    logic       w_enc_write_nxt;
    logic [6:0] r_code_out;
    logic [6:0] w_code_out_nxt;
    logic       r_code_src;
    logic       w_code_src_nxt;
    logic       r_code_valid;
    logic       w_code_valid_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       w_capture;
    logic       w_any;
    logic       w_gnt0;
    logic       w_gnt1;

    // A tie goes to whichever requester was not served last.
    assign w_any  = req0 | req1;
    assign w_gnt1 = req1 & (~req0 | ~r_last_grant);
    assign w_gnt0 = req0 & ~w_gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (r_cnt == 2'd3) begin
                    w_state_nxt = (ENC_LAT == 0) ? S_OUT : S_WAIT;
                end
            end
            S_WAIT:  if (r_wcnt == LAT_LAST) w_state_nxt = S_OUT;
            S_OUT:   if (code_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack0_nxt       = 1'b0;
        w_ack1_nxt       = 1'b0;
        w_enc_write_nxt  = 1'b0;
        w_enc_data_nxt   = 1'b0;
        w_cnt_nxt        = r_cnt;
        w_wcnt_nxt       = r_wcnt;
        w_buf_nxt        = r_buf;
        w_src_nxt        = r_src;
        w_last_nxt       = r_last_grant;
        w_code_out_nxt   = r_code_out;
        w_code_src_nxt   = r_code_src;
        w_code_valid_nxt = r_code_valid;
        w_capture        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_buf_nxt       = w_gnt1 ? data1 : data0;
                    w_src_nxt       = w_gnt1;
                    w_last_nxt      = w_gnt1;
                    w_ack0_nxt      = w_gnt0;
                    w_ack1_nxt      = w_gnt1;
                    w_enc_write_nxt = 1'b1;
                    w_enc_data_nxt  = w_buf_nxt[3];
                    w_cnt_nxt       = 2'd0;
                end
            end
            S_SHIFT: begin
                if (r_cnt != 2'd3) begin
                    // r_cnt names the bit on the wire now; queue up the next one.
                    w_enc_write_nxt = 1'b1;
                    w_enc_data_nxt  = r_buf[2'd2 - r_cnt];
                    w_cnt_nxt       = r_cnt + 2'd1;
                end else begin
                    w_wcnt_nxt = 3'd0;
                    w_capture  = (ENC_LAT == 0);
                end
            end
            S_WAIT: begin
                if (r_wcnt == LAT_LAST) begin
                    w_capture = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 3'd1;
                end
            end
            S_OUT: begin
                if (code_ready) w_code_valid_nxt = 1'b0;
            end
            default: ;
        endcase
        if (w_capture) begin
            w_code_out_nxt   = enc_code;
            w_code_src_nxt   = r_src;
            w_code_valid_nxt = 1'b1;
        end
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= 2'd0;
            r_wcnt       <= 3'd0;
            r_buf        <= 4'd0;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_enc_data   <= 1'b0;
            r_enc_write  <= 1'b0;
            r_code_out   <= 7'd0;
            r_code_src   <= 1'b0;
            r_code_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_buf        <= w_buf_nxt;
            r_src        <= w_src_nxt;
            r_last_grant <= w_last_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_enc_data   <= w_enc_data_nxt;
            r_enc_write  <= w_enc_write_nxt;
            r_code_out   <= w_code_out_nxt;
            r_code_src   <= w_code_src_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign enc_data   = r_enc_data;
    assign enc_write  = r_enc_write;
    assign code_out   = r_code_out;
    assign code_src   = r_code_src;
    assign code_valid = r_code_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Directed bench for hamming_enc_sched: a serial encoder model feeds the main
// instance; two extra instances cover ENC_LAT=0 and ENC_LAT=3 timing.
module tb_hamming_enc_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] data0 = 4'd0, data1 = 4'd0;
    logic       ack0, ack1, enc_data, enc_write;
    logic [6:0] enc_code;
    logic [6:0] code_out;
    logic       code_src, code_valid, busy;
    logic       code_ready = 1'b1;

    logic       l0_req = 1'b0, l3_req = 1'b0;
    logic [3:0] l_data = 4'b1111;
    logic [6:0] l_code = 7'b1111111;
    logic       l_rdy = 1'b1;
    logic       l0_ack, l0_ack1, l0_ed, l0_ew, l0_src, l0_valid, l0_busy;
    logic       l3_ack, l3_ack1, l3_ed, l3_ew, l3_src, l3_valid, l3_busy;
    logic [6:0] l0_code, l3_code;

    int n_checks = 0;
    int n_fail   = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    logic [7:0] exp_q[$];
    bit         gnt_log[$];
    logic [3:0] enc_sr = 4'd0;

    always #5 clk = ~clk;

    hamming_enc_sched #(.ENC_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .enc_data(enc_data), .enc_write(enc_write), .enc_code(enc_code),
        .code_out(code_out), .code_src(code_src), .code_valid(code_valid),
        .code_ready(code_ready), .busy(busy)
    );

    hamming_enc_sched #(.ENC_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req0(l0_req), .data0(l_data), .ack0(l0_ack),
        .req1(1'b0), .data1(4'd0), .ack1(l0_ack1),
        .enc_data(l0_ed), .enc_write(l0_ew), .enc_code(l_code),
        .code_out(l0_code), .code_src(l0_src), .code_valid(l0_valid),
        .code_ready(l_rdy), .busy(l0_busy)
    );

    hamming_enc_sched #(.ENC_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .req0(l3_req), .data0(l_data), .ack0(l3_ack),
        .req1(1'b0), .data1(4'd0), .ack1(l3_ack1),
        .enc_data(l3_ed), .enc_write(l3_ew), .enc_code(l_code),
        .code_out(l3_code), .code_src(l3_src), .code_valid(l3_valid),
        .code_ready(l_rdy), .busy(l3_busy)
    );

    // Encoder model: bit order p1 p2 d1 p3 d2 d3 d4, d1 is the first bit shifted in.
    function automatic logic [6:0] ham(input logic [3:0] n);
        logic d1, d2, d3, d4;
        d1 = n[3]; d2 = n[2]; d3 = n[1]; d4 = n[0];
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

    always @(posedge clk) if (enc_write) enc_sr <= {enc_sr[2:0], enc_data};
    assign enc_code = ham(enc_sr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and grant log.
    always @(negedge clk) begin
        if (ack0 || ack1) check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (ack0) begin ack0_cnt++; gnt_log.push_back(1'b0); end
        if (ack1) begin ack1_cnt++; gnt_log.push_back(1'b1); end
        if (code_valid && code_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_code", 32'({code_src, code_out}), 32'hFFFF);
            end else begin
                check("code_word", 32'({code_src, code_out}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'({ack0, ack1}), 32'd0);
        check("rst_enc", 32'({enc_write, enc_data}), 32'd0);
        check("rst_out", 32'({code_valid, code_src, code_out}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
    endtask

    task automatic wait_ack0(input int limit);
        for (int k = 0; k < limit && !ack0; k++) @(negedge clk);
        check("ack0_seen", 32'(ack0), 32'd1);
    endtask

    task automatic wait_drain(input int limit);
        for (int k = 0; k < limit && (exp_q.size() != 0 || busy); k++) @(negedge clk);
        check("drain_q", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] nib;
        int n, a_snap;
        int t0a, t0v, t3a, t3v, w0, w3;
        logic [6:0] c0, c3;

        repeat (2) @(negedge clk);
        apply_reset();

        // Single request, ENC_LAT=1.
        @(negedge clk);
        nib = 4'b1001; data0 = nib; req0 = 1'b1; code_ready = 1'b1;
        exp_q.push_back({1'b0, 7'b0011001});
        @(negedge clk);
        wait_ack0(4);
        req0 = 1'b0;
        check("t1_write0", 32'(enc_write), 32'd1);
        check("t1_bit0", 32'(enc_data), 32'(nib[3]));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("t1_write", 32'(enc_write), 32'd1);
            check("t1_bit", 32'(enc_data), 32'(nib[3-i]));
            if (i == 1) check("t1_ack_pulse", 32'(ack0), 32'd0);
        end
        @(negedge clk);
        check("t1_wait_write", 32'({enc_write, enc_data, code_valid}), 32'd0);
        @(negedge clk);
        check("t1_valid_lat5", 32'(code_valid), 32'd1);
        check("t1_code", 32'(code_out), 32'h19);
        check("t1_src", 32'(code_src), 32'd0);
        @(negedge clk);
        check("t1_done", 32'({code_valid, busy}), 32'd0);
        check("t1_ack_count", 32'(ack0_cnt), 32'd1);

        // Tie and alternation from a fresh reset.
        apply_reset();
        gnt_log.delete();
        data0 = 4'b0001; data1 = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 7'b1101001});
            exp_q.push_back({1'b1, 7'b0010110});
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 60 && gnt_log.size() < 4; k++) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_drain(40);
        check("t2_grants", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() >= 4) begin
            check("t2_g0", 32'(gnt_log[0]), 32'd0);
            check("t2_g1", 32'(gnt_log[1]), 32'd1);
            check("t2_g2", 32'(gnt_log[2]), 32'd0);
            check("t2_g3", 32'(gnt_log[3]), 32'd1);
        end

        // Backpressure with a request arriving during OUT.
        code_ready = 1'b0;
        data0 = 4'b1001; req0 = 1'b1;
        exp_q.push_back({1'b0, 7'b0011001});
        @(negedge clk);
        wait_ack0(4);
        req0 = 1'b0;
        for (int k = 0; k < 12 && !code_valid; k++) @(negedge clk);
        a_snap = ack1_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                data1 = 4'b0001; req1 = 1'b1;
                exp_q.push_back({1'b1, 7'b1101001});
            end
            check("t3_hold", 32'({code_valid, code_src, code_out}), 32'h119);
            check("t3_no_ack1", 32'(ack1), 32'd0);
        end
        check("t3_ack1_cnt", 32'(ack1_cnt), 32'(a_snap));
        code_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 6 && !ack1; k++) begin @(negedge clk); n++; end
        check("t3_ack1_after_idle", 32'(n), 32'd2);
        req1 = 1'b0;
        wait_drain(20);

        // ENC_LAT=0 and ENC_LAT=3 instances.
        t0a = -1; t0v = -1; t3a = -1; t3v = -1; w0 = 0; w3 = 0; c0 = '0; c3 = '0;
        l0_req = 1'b1; l3_req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (l0_ack) begin t0a = k; l0_req = 1'b0; end
            if (l3_ack) begin t3a = k; l3_req = 1'b0; end
            if (l0_valid && t0v < 0) begin t0v = k; c0 = l0_code; end
            if (l3_valid && t3v < 0) begin t3v = k; c3 = l3_code; end
            if (l0_ew) w0++;
            if (l3_ew) w3++;
        end
        check("t4_lat0", 32'(t0v - t0a), 32'd4);
        check("t4_lat3", 32'(t3v - t3a), 32'd7);
        check("t4_write0", 32'(w0), 32'd4);
        check("t4_write3", 32'(w3), 32'd4);
        check("t4_code0", 32'(c0), 32'h7F);
        check("t4_code3", 32'(c3), 32'h7F);

        // Reset after two serial bits, req0 held across it.
        nib = 4'b1010; data0 = nib; req0 = 1'b1; code_ready = 1'b1;
        @(negedge clk);
        wait_ack0(4);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_async", 32'({enc_write, busy, code_valid}), 32'd0);
        a_snap = ack0_cnt;
        exp_q.push_back({1'b0, 7'b1011010});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wait_ack0(4);
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("t5_write", 32'(enc_write), 32'd1);
            check("t5_bit", 32'(enc_data), 32'(nib[3-i]));
        end
        wait_drain(20);
        check("t5_ack_once", 32'(ack0_cnt), 32'(a_snap + 1));

        // Withdrawn request during SHIFT.
        data0 = 4'b0110; req0 = 1'b1;
        exp_q.push_back({1'b0, 7'b1100110});
        @(negedge clk);
        wait_ack0(4);
        req0 = 1'b0;
        a_snap = ack1_cnt;
        data1 = 4'b1111; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        wait_drain(20);
        repeat (4) @(negedge clk);
        check("t6_no_ack1", 32'(ack1_cnt), 32'(a_snap));

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
